// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for a multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath select and enable.
// Optional performance counters are built when RISCV_CTRL_PERF_CNT_EN is defined.

package riscv_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } immediate_type_e;
endpackage

module riscv_multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            br_eq,
    input  logic            br_lt,
    input  logic            br_ltu,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            adr_src,
    output logic            ir_write,
    output logic            pc_write,
    output logic            pc_lsb_clr,
    output logic            reg_write,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      result_src,
    output immediate_type_e imm_src,
    output alu_op_e         alu_ctrl,
    output logic            illegal_instr,
    output logic            instr_done,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
        StAluWb, StBranch, StJal, StJalr, StLink, StLui, StAuipc, StTrap
    } state_e;

    state_e state_q, state_d, decode_next;
    logic   illegal_q;
    logic   taken;

    // funct3 -> ALU op; alt_ok permits funct7[5] to select SUB on funct3=000
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt,
                                           input logic alt_ok);
        unique case (f3)
            3'b000:  alu_decode = (alt && alt_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            default: alu_decode = ALU_AND;
        endcase
    endfunction

    // Opcode/funct legality check and dispatch target out of DECODE
    always_comb begin
        decode_next = StTrap;
        case (opcode)
            OpLoad:   if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                          decode_next = StMemAdr;
            OpStore:  if (funct3 <= 3'b010) decode_next = StMemAdr;
            OpReg:    if (funct7 == 7'b0000000 ||
                          (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                          decode_next = StExecR;
            OpImm: begin
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0000000) decode_next = StExecI;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000 || funct7 == 7'b0100000) decode_next = StExecI;
                end else begin
                    decode_next = StExecI;
                end
            end
            OpBranch: if (funct3 != 3'b010 && funct3 != 3'b011) decode_next = StBranch;
            OpJal:    decode_next = StJal;
            OpJalr:   if (funct3 == 3'b000) decode_next = StJalr;
            OpLui:    decode_next = StLui;
            OpAuipc:  decode_next = StAuipc;
            default:  decode_next = StTrap;
        endcase
    end

    // Branch condition from funct3 and comparator flags
    always_comb begin
        case (funct3)
            3'b000:  taken = br_eq;
            3'b001:  taken = !br_eq;
            3'b100:  taken = br_lt;
            3'b101:  taken = !br_lt;
            3'b110:  taken = br_ltu;
            3'b111:  taken = !br_ltu;
            default: taken = 1'b0;
        endcase
    end

    // Next state and combinational control outputs, all forced to 0 during reset
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_lsb_clr = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        imm_src    = IMM_I;
        alu_ctrl   = ALU_ADD;
        instr_done = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    state_d    = StDecode;
                end
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (opcode == OpJal) ? IMM_J : IMM_B;
                state_d   = decode_next;
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (opcode == OpStore) ? IMM_S : IMM_I;
                state_d   = (opcode == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_decode(funct3, funct7[5], 1'b1);
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_decode(funct3, funct7[5], 1'b0);
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                pc_write   = taken;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJal: begin
                // PC takes the DECODE target while ALUOut picks up the link value
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = StAluWb;
            end
            StJalr: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_lsb_clr = 1'b1;
                pc_write   = 1'b1;
                state_d    = StLink;
            end
            StLink: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = StAluWb;
            end
            StLui: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = IMM_U;
                state_d   = StAluWb;
            end
            StAuipc: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = IMM_U;
                state_d   = StAluWb;
            end
            default: state_d = StTrap;
        endcase
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_lsb_clr = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            result_src = 2'b00;
            imm_src    = IMM_I;
            alu_ctrl   = ALU_ADD;
            instr_done = 1'b0;
        end
    end

    assign illegal_instr = illegal_q & ~rst;

    // State register and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == StTrap) illegal_q <= 1'b1;
        end
    end

`ifdef RISCV_CTRL_PERF_CNT_EN
    localparam logic [XLEN-1:0] CntOne = XLEN'(1);
    logic [XLEN-1:0] cycle_q, instret_q;

    // Free-running cycle and retired-instruction counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + CntOne;
            if (instr_done) instret_q <= instret_q + CntOne;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed self-checking bench for riscv_multicycle_ctrl.
module tb_riscv_multicycle_ctrl;
    import riscv_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            br_eq, br_lt, br_ltu, mem_ready;
    logic            mem_req, mem_we, adr_src, ir_write, pc_write, pc_lsb_clr, reg_write;
    logic [1:0]      alu_src_a, alu_src_b, result_src;
    immediate_type_e imm_src;
    alu_op_e         alu_ctrl;
    logic            illegal_instr, instr_done;
    logic [XLEN-1:0] cycle_cnt, instret_cnt;

    int n_cmp = 0;
    int n_err = 0;

    riscv_multicycle_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .pc_lsb_clr(pc_lsb_clr), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .alu_ctrl(alu_ctrl), .illegal_instr(illegal_instr),
        .instr_done(instr_done), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    logic [21:0] ctl;
    assign ctl = {mem_req, mem_we, adr_src, ir_write, pc_write, pc_lsb_clr, reg_write,
                  alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal_instr, instr_done};

    function automatic logic [21:0] mk(input logic req, we, adr, irw, pcw, lsb, rw,
                                       input logic [1:0] a, b, rs, input logic [2:0] imm,
                                       input logic [3:0] alu, input logic ill, done);
        return {req, we, adr, irw, pcw, lsb, rw, a, b, rs, imm, alu, ill, done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the current cycle's outputs, then advance one clock
    task automatic step(input string tag, input logic [21:0] exp);
        #1;
        chk(tag, {10'd0, ctl}, {10'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [31:0] ir);
        opcode = ir[6:0];
        funct3 = ir[14:12];
        funct7 = ir[31:25];
    endtask

    logic [21:0] e_zero, e_fetch, e_fwait, e_dec_b, e_dec_j, e_wb, e_xr_add, e_xr_sub;
    logic [21:0] e_xi_add, e_xi_sra, e_ma_l, e_ma_s, e_mrd, e_mwb, e_mwr, e_br_t, e_br_n;
    logic [21:0] e_jal, e_jalr, e_link, e_lui, e_trap;

    initial begin
        e_zero   = '0;
        e_fetch  = mk(1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b10, 2'b10, IMM_I, ALU_ADD, 0, 0);
        e_fwait  = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, IMM_I, ALU_ADD, 0, 0);
        e_dec_b  = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, IMM_B, ALU_ADD, 0, 0);
        e_dec_j  = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, IMM_J, ALU_ADD, 0, 0);
        e_wb     = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, IMM_I, ALU_ADD, 0, 1);
        e_xr_add = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, IMM_I, ALU_ADD, 0, 0);
        e_xr_sub = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, IMM_I, ALU_SUB, 0, 0);
        e_xi_add = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, IMM_I, ALU_ADD, 0, 0);
        e_xi_sra = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, IMM_I, ALU_SRA, 0, 0);
        e_ma_l   = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, IMM_I, ALU_ADD, 0, 0);
        e_ma_s   = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, IMM_S, ALU_ADD, 0, 0);
        e_mrd    = mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, IMM_I, ALU_ADD, 0, 0);
        e_mwb    = mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, IMM_I, ALU_ADD, 0, 1);
        e_mwr    = mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, IMM_I, ALU_ADD, 0, 1);
        e_br_t   = mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, IMM_I, ALU_ADD, 0, 1);
        e_br_n   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, IMM_I, ALU_ADD, 0, 1);
        e_jal    = mk(0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b10, 2'b00, IMM_I, ALU_ADD, 0, 0);
        e_jalr   = mk(0, 0, 0, 0, 1, 1, 0, 2'b10, 2'b01, 2'b10, IMM_I, ALU_ADD, 0, 0);
        e_link   = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, IMM_I, ALU_ADD, 0, 0);
        e_lui    = mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, IMM_U, ALU_ADD, 0, 0);
        e_trap   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, IMM_I, ALU_ADD, 1, 0);

        rst = 1'b1; mem_ready = 1'b1; br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
        set_ir(32'h00B50533);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step("reset", e_zero);
        rst = 1'b0;

        // ADD, zero wait states
        step("add_fetch", e_fetch); step("add_dec", e_dec_b);
        step("add_exec", e_xr_add); step("add_wb", e_wb);
        // SUB
        set_ir(32'h40B50533);
        step("sub_fetch", e_fetch); step("sub_dec", e_dec_b);
        step("sub_exec", e_xr_sub); step("sub_wb", e_wb);
        // LW with two wait states in MEMREAD
        set_ir(32'h0005A503);
        step("lw_fetch", e_fetch); step("lw_dec", e_dec_b); step("lw_adr", e_ma_l);
        mem_ready = 1'b0;
        step("lw_rd_w0", e_mrd); step("lw_rd_w1", e_mrd);
        mem_ready = 1'b1;
        step("lw_rd", e_mrd); step("lw_wb", e_mwb);
        // SW with one fetch wait state
        set_ir(32'h00B52023);
        mem_ready = 1'b0;
        step("sw_fwait", e_fwait);
        mem_ready = 1'b1;
        step("sw_fetch", e_fetch); step("sw_dec", e_dec_b);
        step("sw_adr", e_ma_s); step("sw_wr", e_mwr);
        // BNE taken / not taken, BGEU taken / not taken
        set_ir(32'h00B51463); br_eq = 1'b0;
        step("bne_fetch", e_fetch); step("bne_dec", e_dec_b); step("bne_taken", e_br_t);
        br_eq = 1'b1;
        step("bne2_fetch", e_fetch); step("bne2_dec", e_dec_b); step("bne_ntaken", e_br_n);
        set_ir(32'h00B57463); br_eq = 1'b0; br_ltu = 1'b0;
        step("bgeu_fetch", e_fetch); step("bgeu_dec", e_dec_b); step("bgeu_taken", e_br_t);
        br_ltu = 1'b1;
        step("bgeu2_fetch", e_fetch); step("bgeu2_dec", e_dec_b); step("bgeu_ntaken", e_br_n);
        br_ltu = 1'b0;
        // JAL
        set_ir(32'h0080006F);
        step("jal_fetch", e_fetch); step("jal_dec", e_dec_j);
        step("jal_exec", e_jal); step("jal_wb", e_wb);
        // JALR
        set_ir(32'h000500E7);
        step("jalr_fetch", e_fetch); step("jalr_dec", e_dec_b); step("jalr_exec", e_jalr);
        step("jalr_link", e_link); step("jalr_wb", e_wb);
        // LUI
        set_ir(32'h123450B7);
        step("lui_fetch", e_fetch); step("lui_dec", e_dec_b);
        step("lui_exec", e_lui); step("lui_wb", e_wb);
        // SRAI
        set_ir(32'h40155513);
        step("srai_fetch", e_fetch); step("srai_dec", e_dec_b);
        step("srai_exec", e_xi_sra); step("srai_wb", e_wb);

        // Counters: reset, then three back-to-back ADDIs
        rst = 1'b1;
        step("cnt_rst", e_zero);
        rst = 1'b0;
        chk("cycle_after_rst", cycle_cnt, 32'd0);
        chk("instret_after_rst", instret_cnt, 32'd0);
        set_ir(32'h00150513);
        for (int i = 0; i < 3; i++) begin
            step("addi_fetch", e_fetch); step("addi_dec", e_dec_b);
            step("addi_exec", e_xi_add); step("addi_wb", e_wb);
        end
`ifdef RISCV_CTRL_PERF_CNT_EN
        chk("cycle_cnt", cycle_cnt, 32'd12);
        chk("instret_cnt", instret_cnt, 32'd3);
`else
        chk("cycle_cnt_off", cycle_cnt, 32'd0);
        chk("instret_cnt_off", instret_cnt, 32'd0);
`endif

        // Unknown opcode traps and stays trapped until reset
        set_ir(32'h0000007F);
        step("ill_fetch", e_fetch); step("ill_dec", e_dec_b);
        for (int i = 0; i < 10; i++) step("trap_hold", e_trap);
        rst = 1'b1;
        step("trap_rst", e_zero);
        rst = 1'b0;
        // Bad R-type funct7/funct3 combination
        set_ir(32'h40B51533);
        step("badr_fetch", e_fetch); step("badr_dec", e_dec_b);
        step("badr_trap", e_trap); step("badr_trap2", e_trap);
        rst = 1'b1;
        step("badr_rst", e_zero);
        rst = 1'b0;
        // JALR with nonzero funct3
        set_ir(32'h000510E7);
        step("badjalr_fetch", e_fetch); step("badjalr_dec", e_dec_b);
        step("badjalr_trap", e_trap);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
